// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: source requests/bytes, grant/pop/status strobes and eth_tx payload side of eth_tx_sched
interface eth_tx_sched_if #(parameter int pLEN_W = 11);
  logic [1:0] Src_Req, Src_Rd, Src_Grant, Src_Done, Src_Err;
  logic [pLEN_W-1:0] Src_Len0, Src_Len1;
  logic [7:0] Src_Byte0, Src_Byte1, Eth_Byte;
  logic Eth_Byte_Valid, Eth_Pkt_Rdy, Tx_En, Busy;
  modport master(
    input Src_Req, Src_Len0, Src_Len1, Src_Byte0, Src_Byte1, Tx_En,
    output Src_Rd, Src_Grant, Src_Done, Src_Err, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy
  );
  modport slave(
    output Src_Req, Src_Len0, Src_Len1, Src_Byte0, Src_Byte1, Tx_En,
    input Src_Rd, Src_Grant, Src_Done, Src_Err, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy
  );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin two-source scheduler (Clk, Rst, bus=eth_tx_sched_if.master) padding payloads into eth_tx and enforcing IPG
module eth_tx_sched #(
  parameter int pMIN_PAYLOAD = 46,
  parameter int pMAX_PAYLOAD = 1500,
  parameter int pIPG_CYCLES = 48,
  parameter int pLEN_W = 11
) (
  input logic Clk,
  input logic Rst,
  eth_tx_sched_if.master bus
);
  localparam int IW = $clog2(pIPG_CYCLES + 1);
  localparam logic [pLEN_W-1:0] MIN_L = pLEN_W'(pMIN_PAYLOAD);
  localparam logic [pLEN_W-1:0] MAX_L = pLEN_W'(pMAX_PAYLOAD);
  typedef enum logic [2:0] {IDLE, LOAD, PAD, START, WAIT_TX_START, WAIT_TX_END, IPG} state_t;
  state_t state;
  logic ptr, g, sel;
  logic [pLEN_W-1:0] cnt, cnt_n, len, sel_len;
  logic [IW-1:0] ipg;
  always_comb begin
    sel = bus.Src_Req[ptr] ? ptr : ~ptr;
    sel_len = sel ? bus.Src_Len1 : bus.Src_Len0;
    cnt_n = cnt + pLEN_W'(1);
    bus.Src_Rd = (state == LOAD) ? (g ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      g <= 1'b0;
      cnt <= '0;
      len <= '0;
      ipg <= '0;
      bus.Src_Grant <= 2'b00;
      bus.Src_Done <= 2'b00;
      bus.Src_Err <= 2'b00;
      bus.Eth_Byte <= 8'h00;
      bus.Eth_Byte_Valid <= 1'b0;
      bus.Eth_Pkt_Rdy <= 1'b0;
      bus.Busy <= 1'b0;
    end else begin
      bus.Src_Done <= 2'b00;
      bus.Src_Err <= 2'b00;
      bus.Eth_Byte_Valid <= 1'b0;
      bus.Eth_Pkt_Rdy <= 1'b0;
      case (state)
        IDLE: if (|bus.Src_Req) begin
          if (sel_len == '0 || sel_len > MAX_L) begin
            bus.Src_Err <= sel ? 2'b10 : 2'b01;
            ptr <= ~sel;
          end else begin
            g <= sel;
            len <= sel_len;
            cnt <= '0;
            bus.Src_Grant <= sel ? 2'b10 : 2'b01;
            bus.Busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.Eth_Byte <= g ? bus.Src_Byte1 : bus.Src_Byte0;
          bus.Eth_Byte_Valid <= 1'b1;
          cnt <= cnt_n;
          if (cnt_n == len) state <= (len < MIN_L) ? PAD : START;
        end
        PAD: begin
          bus.Eth_Byte <= 8'h00;
          bus.Eth_Byte_Valid <= 1'b1;
          cnt <= cnt_n;
          if (cnt_n == MIN_L) state <= START;
        end
        START: begin
          bus.Eth_Pkt_Rdy <= 1'b1;
          state <= WAIT_TX_START;
        end
        WAIT_TX_START: if (bus.Tx_En) state <= WAIT_TX_END;
        WAIT_TX_END: if (!bus.Tx_En) begin
          bus.Src_Done <= bus.Src_Grant;
          bus.Src_Grant <= 2'b00;
          ptr <= ~g;
          ipg <= IW'(pIPG_CYCLES - 1);
          state <= IPG;
        end
        IPG: if (ipg == '0) begin
          bus.Busy <= 1'b0;
          state <= IDLE;
        end else ipg <= ipg - IW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed checks of arbitration, padding, framing, IPG, errors and reset
module tb_eth_tx_sched;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  eth_tx_sched_if #(.pLEN_W(11)) bus();
  eth_tx_sched dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  int total = 0;
  int bad = 0;
  int txc = 0;
  int idx [2];
  int nrd [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic upd_bytes();
    bus.Src_Byte0 = 8'(idx[0]);
    bus.Src_Byte1 = 8'(160 + idx[1]);
  endtask
  task automatic tick();
    logic [1:0] rd;
    rd = bus.Src_Rd;
    @(posedge Clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (rd[s]) begin
        idx[s]++;
        nrd[s]++;
      end
      if (bus.Src_Done[s]) idx[s] = 0;
    end
    txc = bus.Eth_Pkt_Rdy ? 1 : (txc > 0 ? txc + 1 : 0);
    if (txc == 4) bus.Tx_En = 1'b1;
    if (txc == 13) begin
      bus.Tx_En = 1'b0;
      txc = 0;
    end
    upd_bytes();
  endtask
  task automatic do_reset();
    Rst = 1'b1;
    bus.Tx_En = 1'b0;
    tick();
    idx = '{0, 0};
    txc = 0;
    upd_bytes();
    Rst = 1'b0;
  endtask
  task automatic run(input int s, input int len);
    int k = 0, fv = -1, lv = -1, nv = 0, rk = -1, nr = 0, dk = -1, bk = -1, bm = 0;
    int g1 = 0, b1 = 0, r1 = 0, ex = 0, mx = 0;
    mx = len > 46 ? len : 46;
    nrd = '{0, 0};
    if (s == 0) bus.Src_Len0 = 11'(len);
    else bus.Src_Len1 = 11'(len);
    bus.Src_Req[s] = 1'b1;
    while (bk < 0 && k < len + 400) begin
      tick();
      k++;
      if (k == 1) begin
        g1 = int'(bus.Src_Grant);
        b1 = int'(bus.Busy);
        r1 = int'(bus.Src_Rd);
      end
      if (bus.Eth_Byte_Valid) begin
        if (fv < 0) fv = k;
        lv = k;
        ex = nv < len ? ((s != 0 ? 160 : 0) + nv) % 256 : 0;
        if (int'(bus.Eth_Byte) != ex) bm++;
        nv++;
      end
      if (bus.Eth_Pkt_Rdy) begin
        rk = k;
        nr++;
      end
      if (bus.Src_Done[s]) begin
        dk = k;
        bus.Src_Req[s] = 1'b0;
      end
      if (dk > 0 && !bus.Busy && bk < 0) bk = k;
    end
    chk("grant_t1", g1, 1 << s);
    chk("busy_t1", b1, 1);
    chk("rd_t1", r1, 1 << s);
    chk("first_valid", fv, 2);
    chk("valid_cnt", nv, mx);
    chk("valid_contig", lv - fv + 1, nv);
    chk("byte_errs", bm, 0);
    chk("src_rd_cnt", nrd[s], len);
    chk("pkt_rdy_cnt", nr, 1);
    chk("pkt_rdy_at", rk, mx + 2);
    chk("done_at", dk, mx + 15);
    chk("ipg_busy_low", bk - dk, 48);
  endtask
  initial begin
    int n, k, d1, v2, q;
    logic [3:0] ord;
    logic pg;
    bus.Src_Req = 2'b00;
    bus.Src_Len0 = '0;
    bus.Src_Len1 = '0;
    bus.Tx_En = 1'b0;
    idx = '{0, 0};
    nrd = '{0, 0};
    upd_bytes();
    do_reset();
    chk("reset_outs", {bus.Src_Rd, bus.Src_Grant, bus.Src_Done, bus.Src_Err, bus.Eth_Byte,
        bus.Eth_Byte_Valid, bus.Eth_Pkt_Rdy, bus.Busy}, 0);
    run(0, 64);
    run(1, 10);
    bus.Src_Len0 = 11'd0;
    bus.Src_Req = 2'b01;
    tick();
    chk("err0", bus.Src_Err, 1);
    chk("err0_grant", bus.Src_Grant, 0);
    chk("err0_busy", bus.Busy, 0);
    bus.Src_Req = 2'b00;
    q = 0;
    repeat (5) begin
      tick();
      q += int'(bus.Eth_Byte_Valid) + int'(|bus.Src_Grant) + int'(|bus.Src_Err);
    end
    chk("err0_quiet", q, 0);
    bus.Src_Len1 = 11'd1501;
    bus.Src_Req = 2'b10;
    tick();
    chk("err1", bus.Src_Err, 2);
    chk("err1_grant", bus.Src_Grant, 0);
    bus.Src_Req = 2'b00;
    tick();
    chk("err1_pulse", bus.Src_Err, 0);
    bus.Src_Len0 = 11'd100;
    bus.Src_Req = 2'b01;
    repeat (21) tick();
    chk("mid_load_pops", idx[0], 20);
    do_reset();
    chk("rst_mid_outs", {bus.Src_Rd, bus.Src_Grant, bus.Src_Done, bus.Src_Err, bus.Eth_Byte,
        bus.Eth_Byte_Valid, bus.Eth_Pkt_Rdy, bus.Busy}, 0);
    run(0, 100);
    bus.Src_Len0 = 11'd46;
    bus.Src_Len1 = 11'd46;
    bus.Src_Req = 2'b11;
    do_reset();
    ord = 4'b0000;
    n = 0;
    k = 0;
    d1 = -1;
    v2 = -1;
    pg = 1'b0;
    while (n < 4 && k < 2000) begin
      tick();
      k++;
      if (|bus.Src_Grant && !pg) begin
        ord = {ord[2:0], bus.Src_Grant[1]};
        n++;
      end
      pg = |bus.Src_Grant;
      if (|bus.Src_Done && d1 < 0) d1 = k;
      if (d1 > 0 && v2 < 0 && bus.Eth_Byte_Valid) v2 = k;
    end
    chk("rr_count", n, 4);
    chk("rr_order", ord, 4'b0101);
    chk("rr_gap", v2 - d1, 50);
    bus.Src_Req = 2'b00;
    do_reset();
    run(0, 1500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler in front of `eth_tx`. It arbitrates round-robin between two packet sources and streams the winner's payload bytes into the `eth_tx` payload FIFO. It zero-pads short payloads to the Ethernet minimum, pulses `Eth_Pkt_Rdy`, tracks the frame on `Tx_En`, and enforces the inter-packet gap before granting the next source.

## Interface
Parameters:
- pMIN_PAYLOAD, 46: minimum payload bytes; shorter payloads are zero-padded.
- pMAX_PAYLOAD, 1500: maximum legal payload length.
- pIPG_CYCLES, 48: idle clocks after `Tx_En` falls (96 bit times at 2 bits/clk).
- pLEN_W, 11: width of the length fields.

Ports:
- Clk  in  1  system clock (RMII 50 MHz); the block has one clock.
- Rst  in  1  reset, synchronous, active-high.
- Src_Req  in  2  per-source request; held high until that source's `Src_Done` or `Src_Err`.
- Src_Len0, Src_Len1  in  pLEN_W  payload length; stable while the request is high.
- Src_Byte0, Src_Byte1  in  8  current payload byte (first-word-fall-through).
- Src_Rd  out  2  per-source pop strobe; the source presents its next byte on the following cycle.
- Src_Grant  out  2  one-hot grant, held from arbitration until `Src_Done`.
- Src_Done  out  2  one-cycle pulse when the granted frame finishes on the wire.
- Src_Err  out  2  one-cycle pulse when a request is rejected for illegal length.
- Eth_Byte  out  8  payload byte to `eth_tx`.
- Eth_Byte_Valid  out  1  write strobe to the `eth_tx` FIFO.
- Eth_Pkt_Rdy  out  1  one-cycle start pulse to `eth_tx`.
- Tx_En  in  1  `eth_tx` transmit enable, used for frame tracking.
- Busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has seven states: IDLE, LOAD, PAD, START, WAIT_TX_START, WAIT_TX_END, IPG.
- **IDLE:** if any `Src_Req` bit is high, pick a source round-robin, beginning with the source after the last one serviced. After reset the priority pointer selects source 0.
  - If the chosen source's length is 0 or greater than pMAX_PAYLOAD, pulse its `Src_Err`, advance the pointer, and stay in IDLE.
  - Otherwise set its `Src_Grant`, clear the byte counter, and go to LOAD.
- **LOAD:** each cycle, `Src_Rd[g]` is high combinationally and the counter increments.
  - Registered: `Eth_Byte <= Src_Byte_g` and `Eth_Byte_Valid <= 1`.
  - When the counter reaches Len, go to PAD if Len < pMIN_PAYLOAD, otherwise go to START.
- **PAD:** register `Eth_Byte` = 0x00 with `Eth_Byte_Valid` = 1 until a total of pMIN_PAYLOAD bytes have been written, then go to START.
- **START:** register `Eth_Pkt_Rdy` = 1 for exactly one cycle, then go to WAIT_TX_START.
- **WAIT_TX_START:** wait for `Tx_En` = 1, then go to WAIT_TX_END.
- **WAIT_TX_END:** on `Tx_En` = 0, pulse `Src_Done[g]` (registered), clear `Src_Grant`, set the pointer to the other source, load the IPG counter, and go to IPG.
- **IPG:** count pIPG_CYCLES clocks, then go to IDLE. Requests raised during IPG are held and not granted until IDLE.
- Byte counter width is pLEN_W. The total bytes written equal max(Len, pMIN_PAYLOAD); counter wrap is impossible because Len ≤ pMAX_PAYLOAD is checked.
- **Simultaneous requests:** only the pointer decides; the other source waits a full frame plus IPG.
- **Request dropped mid-LOAD:** this is a protocol violation. The FSM still completes Len pops, and the resulting data is undefined.
- **Reset mid-operation:** the FSM returns to IDLE and all outputs go to 0. Rst also flushes the `eth_tx` FIFO, so any partial frame is discarded.

## Timing
- Reset value 0 on every output: `Src_Rd`, `Src_Grant`, `Src_Done`, `Src_Err`, `Eth_Byte`, `Eth_Byte_Valid`, `Eth_Pkt_Rdy`, `Busy`.
- All outputs are registered except `Src_Rd`.
- Request sampled in IDLE at cycle T:
  - `Src_Grant` and `Busy` are high at T+1.
  - The first `Src_Rd` is at T+1.
  - The first `Eth_Byte_Valid` is at T+2.
- `Eth_Byte_Valid` is contiguous for max(Len, pMIN_PAYLOAD) cycles with no gaps.
- `Eth_Pkt_Rdy` is high exactly one cycle, the cycle after the last `Eth_Byte_Valid`.
- `Src_Done` is asserted in the cycle after `Tx_En` is first sampled low in WAIT_TX_END.
- The earliest next grant is pIPG_CYCLES + 1 cycles after `Src_Done`.
- `Src_Err` is asserted the cycle after the illegal request is sampled. No other output changes.

## Test plan
- Source 0 only, Len=64, bytes 0x00..0x3F:
  - Grant0 at T+1.
  - 64 contiguous `Eth_Byte_Valid` cycles carrying 0x00..0x3F.
  - One `Eth_Pkt_Rdy` pulse.
  - `Src_Done[0]` after a modelled `Tx_En` drop.
  - Busy low 48 cycles later.
- Source 1, Len=10, bytes 0xA0..0xA9:
  - 10 source bytes, then 36 bytes of 0x00 (46 valid cycles total).
  - Exactly 10 `Src_Rd[1]` pulses.
- Both requests held high from reset, Len0=Len1=46:
  - Service order 0, 1, 0, 1.
  - The second frame's first `Eth_Byte_Valid` is no earlier than 49 cycles after the first `Src_Done`.
- Illegal lengths:
  - Len0=0 → `Src_Err[0]` pulse, no grant, `Eth_Byte_Valid` stays 0.
  - Len1=1501 → `Src_Err[1]` pulse.
- Rst asserted for 1 cycle in the middle of LOAD (byte 20 of 100):
  - All outputs 0 the next cycle, FSM in IDLE.
  - A still-held source-0 request is re-granted from byte 0.
- Len=1500:
  - 1500 valid cycles, no padding.
  - `Eth_Pkt_Rdy` at cycle T+1502 relative to the sampled request.
